// File: rtl/nt_node_stim_gen.sv
// Pattern generator and response compactor for an Nt-node-under-test: LFSR stimulus over valid/ready, MISR signature.
// Optional golden-signature compare is enabled by defining NT_STIM_GOLDEN_CMP_EN.
module nt_node_stim_gen #(
    parameter int STIM_W   = 4,
    parameter int LFSR_W   = 16,
    parameter int NUM_VEC  = 256,
    parameter int RESP_LAT = 2
) (
    input  logic              I1470,
    input  logic              I1477,
    input  logic              start,
    input  logic [15:0]       seed,
    output logic [STIM_W-1:0] stim,
    output logic              stim_valid,
    input  logic              stim_ready,
    input  logic              resp,
    output logic              busy,
    output logic              done,
    output logic [15:0]       signature,
    output logic [15:0]       vec_cnt
`ifdef NT_STIM_GOLDEN_CMP_EN
    ,
    input  logic [15:0]       golden_sig,
    output logic              mismatch
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [LFSR_W-1:0] misr_step(input logic [LFSR_W-1:0] s, input logic r);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {15'b0, r};
    endfunction

    state_t              state_r;
    logic [LFSR_W-1:0]   lfsr_r;
    logic [LFSR_W-1:0]   sig_r;
    logic [15:0]         cnt_r;
    logic [RESP_LAT-1:0] vpipe_r;
    logic                valid_r;
    logic                busy_r;
    logic                done_r;
    logic                xfer_s;
    logic [RESP_LAT-1:0] pipe_next_s;

    assign xfer_s = (state_r == ST_RUN) && valid_r && stim_ready;

    // Valid pipeline: each transfer launches a token that reaches the output stage RESP_LAT-1 edges later
    always_comb begin
        pipe_next_s    = vpipe_r << 1;
        pipe_next_s[0] = xfer_s;
    end

    // Control FSM, pattern LFSR, MISR and vector counter
    always_ff @(posedge I1470 or posedge I1477) begin
        if (I1477) begin
            state_r  <= ST_IDLE;
            lfsr_r   <= 16'h0001;
            sig_r    <= 16'h0000;
            cnt_r    <= 16'h0000;
            vpipe_r  <= {RESP_LAT{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef NT_STIM_GOLDEN_CMP_EN
            mismatch <= 1'b0;
`endif
        end else begin
            vpipe_r <= pipe_next_s;
            // Token at the output stage means resp now belongs to an accepted vector
            if (vpipe_r[RESP_LAT-1]) begin
                sig_r <= misr_step(sig_r, resp);
            end
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r  <= ST_SEED;
                        lfsr_r   <= (seed == 16'h0000) ? 16'h0001 : seed;
                        sig_r    <= 16'h0000;
                        cnt_r    <= 16'h0000;
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
`ifdef NT_STIM_GOLDEN_CMP_EN
                        mismatch <= 1'b0;
`endif
                    end
                end
                ST_SEED: begin
                    state_r <= ST_RUN;
                    valid_r <= 1'b1;
                end
                ST_RUN: begin
                    if (xfer_s) begin
                        lfsr_r <= lfsr_step(lfsr_r);
                        cnt_r  <= cnt_r + 16'd1;
                        if (cnt_r == 16'(NUM_VEC - 1)) begin
                            state_r <= ST_DRAIN;
                            valid_r <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (vpipe_r == {RESP_LAT{1'b0}}) begin
                        state_r  <= ST_DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
`ifdef NT_STIM_GOLDEN_CMP_EN
                        mismatch <= (sig_r != golden_sig);
`endif
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign stim       = lfsr_r[STIM_W-1:0];
    assign stim_valid = valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign signature  = sig_r;
    assign vec_cnt    = cnt_r;

endmodule

// File: tb/tb_nt_node_stim_gen.sv
// Randomized bench for nt_node_stim_gen: per-vector responses are folded into a reference signature.
// A second instance with NUM_VEC=1 and resp tied high covers the single-vector case.
module tb_nt_node_stim_gen;

    localparam int NV = 4;
    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stim_ready = 1'b0;
    logic        resp = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic [3:0]  stim;
    logic        stim_valid, busy, done;
    logic [15:0] signature, vec_cnt;
    logic [3:0]  stim1;
    logic        valid1, busy1, done1;
    logic [15:0] sig1, cnt1;
`ifdef NT_STIM_GOLDEN_CMP_EN
    logic [15:0] golden_sig = 16'h0000;
    logic [15:0] golden1 = 16'h0000;
    logic        mismatch, mismatch1;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    int          ec = 0;
    logic [NV-1:0] rbits;
    int          pend_e[$];
    logic        pend_v[$];
    logic [15:0] sig_a, sig_b;

    always #5 clk = ~clk;

    nt_node_stim_gen #(.STIM_W(4), .LFSR_W(16), .NUM_VEC(NV), .RESP_LAT(RL)) dut (
        .I1470(clk), .I1477(rst), .start(start), .seed(seed),
        .stim(stim), .stim_valid(stim_valid), .stim_ready(stim_ready), .resp(resp),
        .busy(busy), .done(done), .signature(signature), .vec_cnt(vec_cnt)
`ifdef NT_STIM_GOLDEN_CMP_EN
        , .golden_sig(golden_sig), .mismatch(mismatch)
`endif
    );

    nt_node_stim_gen #(.STIM_W(4), .LFSR_W(16), .NUM_VEC(1), .RESP_LAT(RL)) dut1 (
        .I1470(clk), .I1477(rst), .start(start), .seed(seed),
        .stim(stim1), .stim_valid(valid1), .stim_ready(stim_ready), .resp(1'b1),
        .busy(busy1), .done(done1), .signature(sig1), .vec_cnt(cnt1)
`ifdef NT_STIM_GOLDEN_CMP_EN
        , .golden_sig(golden1), .mismatch(mismatch1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic r);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {15'b0, r};
    endfunction

    // One full run: mode 0 = always ready, 1 = ready pattern 1,0,0,1, other = random ready
    task automatic run_once(input logic [15:0] sd, input int mode, input bit poke_start,
                            output logic [15:0] sig_out);
        logic [15:0] l, s;
        int acc;
        bit fin, rdy;
        l = (sd == 16'h0000) ? 16'h0001 : sd;
        s = 16'h0000;
        acc = 0;
        fin = 1'b0;
        pend_e.delete();
        pend_v.delete();
        seed = sd;
        start = 1'b1;
        stim_ready = 1'b0;
        resp = 1'($urandom);
        @(negedge clk); ec++;
        start = 1'b0;
        check("seed_busy", busy, 1);
        check("seed_done", done, 0);
        check("seed_valid", stim_valid, 0);
`ifdef NT_STIM_GOLDEN_CMP_EN
        check("mismatch_clr", mismatch, 0);
`endif
        for (int it = 0; it < 200 && !fin; it++) begin
            check("vec_cnt_run", vec_cnt, acc);
            if (stim_valid) check("stim_val", stim, l[3:0]);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((it % 4) == 0) || ((it % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            stim_ready = rdy;
            start = poke_start && (it == 3);
            seed = 16'($urandom);
            if (stim_valid && rdy) begin
                pend_e.push_back(ec + 1 + RL);
                pend_v.push_back(rbits[acc % NV]);
                s = misr_next(s, rbits[acc % NV]);
                l = lfsr_next(l);
                acc++;
            end
            if (pend_e.size() > 0 && pend_e[0] == ec + 1) begin
                resp = pend_v[0];
                void'(pend_e.pop_front());
                void'(pend_v.pop_front());
            end else begin
                resp = 1'($urandom);
            end
            @(negedge clk); ec++;
            start = 1'b0;
            if (done) fin = 1'b1;
        end
        check("done_timeout", fin, 1);
        check("sig", signature, s);
        check("vec_cnt_done", vec_cnt, NV);
        check("accepts", acc, NV);
        check("busy_done", busy, 0);
        check("valid_done", stim_valid, 0);
        check("pend_empty", pend_e.size(), 0);
        check("nv1_done", done1, 1);
        check("nv1_sig", sig1, 16'h0001);
        check("nv1_cnt", cnt1, 1);
`ifdef NT_STIM_GOLDEN_CMP_EN
        check("mismatch", mismatch, (s != golden_sig) ? 1 : 0);
`endif
        // DONE must hold its results regardless of ready/resp activity
        stim_ready = 1'($urandom);
        resp = 1'($urandom);
        @(negedge clk); ec++;
        check("sig_hold", signature, s);
        check("done_hold", done, 1);
        sig_out = s;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", stim_valid, 0);
        check("rst_sig", signature, 16'h0000);
        check("rst_cnt", vec_cnt, 0);
        check("rst_stim", stim, 4'h1);
        rst = 1'b0;
        @(negedge clk);

        // Seed 1, all responses zero: stim 1,2,4,8 and signature stays zero
        rbits = '0;
        run_once(16'h0001, 0, 1'b0, sig_a);
        check("t1_sig_zero", signature, 16'h0000);

        // Zero seed is replaced by 1
        rbits = 4'($urandom);
        run_once(16'h0000, 0, 1'b0, sig_a);

        // Stalled run must give the same signature as an unstalled one for the same responses
        rbits = 4'($urandom);
        run_once(16'h5A5A, 1, 1'b0, sig_a);
        run_once(16'h5A5A, 0, 1'b0, sig_b);
        check("stall_vs_nostall", signature, sig_a);

        // Random runs with an ignored start pulse mid-run
        for (int r = 0; r < 8; r++) begin
            rbits = 4'($urandom);
`ifdef NT_STIM_GOLDEN_CMP_EN
            golden_sig = 16'($urandom);
`endif
            run_once(16'($urandom), 2, 1'b1, sig_b);
        end

`ifdef NT_STIM_GOLDEN_CMP_EN
        rbits = '0;
        golden_sig = 16'h0000;
        run_once(16'h0001, 0, 1'b0, sig_b);
        check("golden_match", mismatch, 0);
        golden_sig = 16'h1234;
        run_once(16'h0001, 0, 1'b0, sig_b);
        check("golden_miss", mismatch, 1);
        golden_sig = 16'h0000;
`endif

        // Reset mid-run, then the same seed must reproduce the earlier signature
        rbits = 4'($urandom);
        run_once(16'hACE1, 0, 1'b0, sig_a);
        seed = 16'hACE1;
        start = 1'b1;
        stim_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", stim_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sig", signature, 16'h0000);
        check("mid_rst_cnt", vec_cnt, 0);
        check("mid_rst_stim", stim, 4'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_once(16'hACE1, 0, 1'b0, sig_b);
        check("repro_sig", signature, sig_a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nt_node_stim_gen.md
Name: nt_node_stim_gen

Overview:
- Stimulus-side counterpart to the Nt-node observation subcircuits in the trojan-detection benchmark set.
- Generates pseudo-random input vectors for a node-under-test (NUT) subcircuit with a valid/ready handshake.
- Collects the NUT's 1-bit response after a fixed latency and compacts the responses into a signature register (MISR).
- Sits in the benchmark harness between the test controller and the gate-level NUT netlist.

Parameters:
- STIM_W, 4, number of stimulus bits driven to the NUT (1..16)
- LFSR_W, 16, width of the pattern LFSR and of the MISR (fixed at 16; taps below assume 16)
- NUM_VEC, 256, vectors per run (1..65535)
- RESP_LAT, 2, cycles from vector acceptance to a valid NUT response (1..8)

Ports:
- I1470  input  1  clock; all state updates on the rising edge
- I1477  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE
- seed  input  16  LFSR seed, sampled on an accepted start
- stim  output  STIM_W  vector to the NUT, equal to lfsr[STIM_W-1:0]
- stim_valid  output  1  stim holds a vector
- stim_ready  input  1  NUT harness accepts stim this cycle
- resp  input  1  NUT output, sampled RESP_LAT cycles after acceptance
- busy  output  1  high in SEED, RUN or DRAIN
- done  output  1  high in DONE
- signature  output  16  MISR contents
- vec_cnt  output  16  number of vectors accepted in the current run

Behaviour:
- Reset (async, I1477=1) values:
  - state=IDLE; lfsr=16'h0001; signature=16'h0000; vec_cnt=0.
  - stim_valid=0, busy=0, done=0; response pipeline cleared.
- States: IDLE, SEED, RUN, DRAIN, DONE.
- IDLE / DONE + start:
  - Go to SEED.
  - lfsr := seed; if seed==0, lfsr := 16'h0001.
  - signature := 0; vec_cnt := 0; done deasserts next cycle.
- SEED: one cycle; stim_valid=0; then go to RUN.
- RUN:
  - stim_valid=1.
  - Transfer occurs when stim_valid & stim_ready.
  - On a transfer: lfsr advances, vec_cnt increments, and a 1 enters the RESP_LAT-deep valid shift pipeline; otherwise a 0 enters.
  - stim and lfsr are held stable while stim_ready=0.
  - After the transfer that makes vec_cnt==NUM_VEC, go to DRAIN; stim_valid=0 from the next cycle.
- LFSR step (Fibonacci, shift left): fb = l[15]^l[13]^l[12]^l[10]; l := {l[14:0], fb}. It never reaches zero.
- MISR step: when the pipeline's output stage is 1, s := {s[14:0], s[15]^s[13]^s[12]^s[10]} ^ {15'b0, resp}. Otherwise s is held.
- Response timing: resp is sampled exactly RESP_LAT rising edges after the accepting edge, whether or not later transfers stall.
- DRAIN: stay until the valid pipeline is all zero, then go to DONE. The last signature update occurs before DONE asserts.
- DONE: done=1, signature and vec_cnt held until the next start.
- start in SEED/RUN/DRAIN: ignored; no restart, no error.
- Reset mid-run: immediate return to reset values; partial signature discarded.
- stim_ready high in non-RUN states: no effect.

Optional Feature:
- Macro: NT_STIM_GOLDEN_CMP_EN.
- With the macro defined:
  - Adds input golden_sig[15:0] and output mismatch (1 bit).
  - On entry to DONE, mismatch := (signature != golden_sig), registered.
  - mismatch is cleared by reset and by an accepted start.
- Without the macro: neither port exists, and no compare logic is present.

Test Plan:
- Reset then start, seed=16'h0001, stim_ready=1 constantly, resp=0, NUM_VEC=4 -> accepted stim sequence 4'h1, 4'h2, 4'h4, 4'h8. Signature stays 16'h0000. done asserts; vec_cnt=4.
- Seed=16'h0000 -> first stim=4'h1 (zero seed replaced by 16'h0001).
- NUM_VEC=1, RESP_LAT=2, resp=1 at the sample edge -> signature=16'h0001 when done rises.
- stim_ready toggling 1,0,0,1 during RUN -> stim held across stall cycles. Each vector is accepted once. vec_cnt increments only on transfers. Signature matches the no-stall run for the same resp stream.
- Assert I1477 for one cycle mid-RUN -> all outputs at reset values asynchronously. A subsequent start with the same seed reproduces the first run's signature.
- NT_STIM_GOLDEN_CMP_EN defined, golden_sig=16'h0000, resp=0 -> mismatch=0. Repeat with golden_sig=16'h1234 -> mismatch=1 in DONE; cleared by the next start.
